// File: rtl/sync_counter_pkg.sv
// sync_counter_pkg: shared constants and helpers for the sync_counter up/down counter.
package sync_counter_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  function automatic logic [31:0] max_count(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/sync_counter_next.sv
// sync_counter_next: combinational next value and wrap detect for an up/down counter.
module sync_counter_next
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));
  always_comb begin
    next = (up == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
    wrap = (up == DIR_UP) ? (count == MAX) : (count == '0);
  end
endmodule

// File: rtl/sync_counter.sv
// sync_counter: free-running up/down counter with async active-high reset.
// Define SYNC_COUNTER_TC_EN to add the terminal-count output tc.
module sync_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  output logic [WIDTH-1:0] count
`ifdef SYNC_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);
  logic [WIDTH-1:0] next;
  logic             wrap;
  sync_counter_next #(.WIDTH(WIDTH)) u_next (
    .count(count),
    .up(up),
    .next(next),
    .wrap(wrap)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= next;
`ifdef SYNC_COUNTER_TC_EN
  assign tc = wrap & ~rst;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif
endmodule

// File: tb/tb_sync_counter.sv
// tb_sync_counter: directed test of sync_counter (WIDTH=4 and WIDTH=1) against a modular-arithmetic model.
module tb_sync_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b1;
  logic [3:0] count4;
  logic [0:0] count1;
  int         pass = 0;
  int         total = 0;
  int         m4 = 0;
  int         m1 = 0;
  int         dn[6] = '{2, 1, 0, 15, 14, 13};
`ifdef SYNC_COUNTER_TC_EN
  logic tc4, tc1;
`endif

  always #5 clk = ~clk;

  sync_counter #(.WIDTH(4)) u4 (
    .clk(clk),
    .rst(rst),
    .up(up),
    .count(count4)
`ifdef SYNC_COUNTER_TC_EN
    ,
    .tc(tc4)
`endif
  );

  sync_counter #(.WIDTH(1)) u1 (
    .clk(clk),
    .rst(rst),
    .up(up),
    .count(count1)
`ifdef SYNC_COUNTER_TC_EN
    ,
    .tc(tc1)
`endif
  );

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference: value modulo 2^W, stepped +1 or -1 on each non-reset edge
  always @(posedge clk or posedge rst)
    if (rst) begin
      m4 <= 0;
      m1 <= 0;
    end else begin
      m4 <= up ? (m4 + 1) % 16 : (m4 + 15) % 16;
      m1 <= (m1 + 1) % 2;
    end

  always @(negedge clk) begin
    check("model_w4", int'(count4), m4);
    check("model_w1", int'(count1), m1);
`ifdef SYNC_COUNTER_TC_EN
    check("model_tc_w4", int'(tc4), int'(!rst && ((up && m4 == 15) || (!up && m4 == 0))));
    check("model_tc_w1", int'(tc1), int'(!rst && ((up && m1 == 1) || (!up && m1 == 0))));
`endif
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", int'(count4), 0);
    #1 rst = 1'b0; up = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset", int'(count4), 5);
    #2 rst = 1'b1; up = 1'b0;
    #1 check("async_clear", int'(count4), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hold", int'(count4), 0);
`ifdef SYNC_COUNTER_TC_EN
      check("tc_in_reset", int'(tc4), 0);
`endif
    end
    #1 rst = 1'b0; up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("count_up", int'(count4), i % 16);
      check("toggle_up_w1", int'(count1), i % 2);
`ifdef SYNC_COUNTER_TC_EN
      check("tc_up", int'(tc4), int'(i == 15));
`endif
    end
    #1 up = 1'b0;
    @(negedge clk);
    check("down_to_3", int'(count4), 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("count_down", int'(count4), dn[k]);
      check("toggle_down_w1", int'(count1), dn[k] % 2);
`ifdef SYNC_COUNTER_TC_EN
      check("tc_down", int'(tc4), int'(dn[k] == 0));
`endif
    end
    #1 up = 1'b1;
    repeat (10) @(negedge clk);
    check("at_7", int'(count4), 7);
    #1 up = 1'b0;
    @(negedge clk) check("switch_down_a", int'(count4), 6);
    @(negedge clk) check("switch_down_b", int'(count4), 5);
    #1 up = 1'b1;
    @(negedge clk) check("switch_up_a", int'(count4), 6);
    @(negedge clk) check("switch_up_b", int'(count4), 7);
    repeat (2) @(negedge clk);
    check("at_9", int'(count4), 9);
    #2 rst = 1'b1;
    #1 check("async_mid", int'(count4), 0);
    @(negedge clk);
    #1 rst = 1'b0; up = 1'b1;
    @(negedge clk) check("release", int'(count4), 1);
    @(negedge clk) check("before_race", int'(count4), 2);
    #5 rst = 1'b1;
    @(negedge clk) check("rst_wins_edge", int'(count4), 0);
    #1 rst = 1'b0;
    @(negedge clk) check("resume", int'(count4), 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
